// File: rtl/shift_reg_4bit_siso.sv
// Serial-in/serial-out shift register with shift enable, direction select and parallel view.
// Optional parallel load is compiled in with `define SHIFT_REG_PLOAD_EN.
module shift_reg_4bit_siso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in,
  input  logic             en,
  input  logic             dir,
`ifdef SHIFT_REG_PLOAD_EN
  input  logic             pload,
  input  logic [WIDTH-1:0] pdata,
`endif
  output logic             out,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("shift_reg_4bit_siso: WIDTH must be in 2..32");
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end
`ifdef SHIFT_REG_PLOAD_EN
    else if (pload) begin
      q <= pdata;
    end
`endif
    else if (en) begin
      if (dir) begin
        q <= {in, q[WIDTH-1:1]};
      end else begin
        q <= {q[WIDTH-2:0], in};
      end
    end
  end

  // Output taps whichever end the data is currently moving toward; follows dir without a register.
  assign out = dir ? q[0] : q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_4bit_siso.sv
// Self-checking bench for shift_reg_4bit_siso: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_shift_reg_4bit_siso;
  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         clr;
  logic         in;
  logic         en;
  logic         dir;
  logic         pload;
  logic [W-1:0] pdata;
  logic         out;
  logic [W-1:0] q;

  int           checks;
  int           errors;
  logic [W-1:0] m_q;
  logic         m_out;

  shift_reg_4bit_siso #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .in    (in),
    .en    (en),
    .dir   (dir),
`ifdef SHIFT_REG_PLOAD_EN
    .pload (pload),
    .pdata (pdata),
`endif
    .out   (out),
    .q     (q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: value of the register after one edge, computed as integer arithmetic.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic c, input logic pl,
                                              input logic [W-1:0] pd, input logic e, input logic d,
                                              input logic i);
    int v;
    v = int'(cur);
    if (c) return '0;
    if (pl) return pd;
    if (!e) return cur;
    if (!d) v = ((v * 2) + int'(i)) % (MASK + 1);
    else    v = (v / 2) + (int'(i) << (W - 1));
    return W'(v);
  endfunction

  task automatic drive(input logic c, input logic i, input logic e, input logic d,
                       input logic pl, input logic [W-1:0] pd);
    @(negedge clk);
    clr = c; in = i; en = e; dir = d;
`ifdef SHIFT_REG_PLOAD_EN
    pload = pl; pdata = pd;
`else
    pload = 1'b0; pdata = pd;
`endif
    @(posedge clk);
    m_q = model_next(m_q, c, pload, pd, e, d, i);
    m_out = d ? m_q[0] : m_q[W-1];
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL reset_q: got %b expected %b", q, 4'b0000); end
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL reset_out: got %b expected %b", out, 1'b0); end
  endtask

  task automatic test_left_stream();
    logic hist[$];
    logic b;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 11; k++) begin
      b = ((k % 4) >= 2);
      hist.push_back(b);
      drive(1'b0, b, 1'b1, 1'b0, 1'b0, '0);
      if (k == 3) begin
        checks++;
        if (q !== 4'b0011) begin errors++; $display("FAIL left_q4: got %b expected %b", q, 4'b0011); end
      end
      if (k >= W - 1) begin
        checks++;
        if (out !== hist[k - (W - 1)])
          begin errors++; $display("FAIL left_latency[%0d]: got %b expected %b", k, out, hist[k - (W - 1)]); end
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, k[0], 1'b0, 1'b0, 1'b0, '0);
      checks++;
      if (q !== 4'b0011 || out !== 1'b0)
        begin errors++; $display("FAIL hold[%0d]: got q=%b out=%b expected q=0011 out=0", k, q, out); end
    end
  endtask

  task automatic test_dir_switch();
    // Register holds 0011; out must follow dir with no clock edge.
    @(negedge clk);
    dir = 1'b1;
    #1;
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL dir_switch_lsb: got %b expected %b", out, 1'b1); end
    dir = 1'b0;
    #1;
    checks++;
    if (out !== 1'b0) begin errors++; $display("FAIL dir_switch_msb: got %b expected %b", out, 1'b0); end
  endtask

  task automatic test_right_shift();
    logic [W-1:0] exp_q [4];
    exp_q[0] = 4'b1000; exp_q[1] = 4'b0100; exp_q[2] = 4'b0010; exp_q[3] = 4'b0001;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, (k == 0), 1'b1, 1'b1, 1'b0, '0);
      checks++;
      if (q !== exp_q[k]) begin errors++; $display("FAIL right_q[%0d]: got %b expected %b", k, q, exp_q[k]); end
    end
    checks++;
    if (out !== 1'b1) begin errors++; $display("FAIL right_out: got %b expected %b", out, 1'b1); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (q !== 4'b1011) begin errors++; $display("FAIL mid_preload: got %b expected %b", q, 4'b1011); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (q !== 4'b0000 || out !== 1'b0)
      begin errors++; $display("FAIL mid_clear: got q=%b out=%b expected q=0000 out=0", q, out); end
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    checks++;
    if (q !== 4'b0001) begin errors++; $display("FAIL mid_resume: got %b expected %b", q, 4'b0001); end
  endtask

`ifdef SHIFT_REG_PLOAD_EN
  task automatic test_pload();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1010);
    checks++;
    if (q !== 4'b1010 || out !== 1'b1)
      begin errors++; $display("FAIL pload: got q=%b out=%b expected q=1010 out=1", q, out); end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1111);
    checks++;
    if (q !== 4'b0000) begin errors++; $display("FAIL pload_clr_priority: got %b expected %b", q, 4'b0000); end
  endtask
`endif

  task automatic test_random();
    logic c, i, e, d, pl;
    logic [W-1:0] pd;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 300; k++) begin
      c  = ($urandom_range(0, 15) == 0);
      i  = 1'($urandom_range(0, 1));
      e  = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 7) == 0) ? ~dir : dir;
      pl = ($urandom_range(0, 11) == 0);
      pd = W'($urandom_range(0, MASK));
      drive(c, i, e, d, pl, pd);
      checks++;
      if (q !== m_q || out !== m_out)
        begin errors++; $display("FAIL random[%0d]: got q=%b out=%b expected q=%b out=%b", k, q, out, m_q, m_out); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_q    = '0;
    m_out  = 1'b0;
    clr = 1'b1; in = 1'b0; en = 1'b0; dir = 1'b0; pload = 1'b0; pdata = '0;
    test_reset();
    test_left_stream();
    test_hold();
    test_dir_switch();
    test_right_shift();
    test_reset_mid();
`ifdef SHIFT_REG_PLOAD_EN
    test_pload();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_reg_4bit_siso.md
Name: shift_reg_4bit_siso

Overview:
- Serial-in/serial-out shift register, 4 stages by default; delays a 1-bit serial stream by WIDTH clock cycles.
- Used as a bit-delay or serializer stage between serial datapath blocks.
- Adds shift enable, direction select and a parallel read-out of the stage contents.

Parameters:
- WIDTH, 4, number of register stages (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  reset, synchronous and active-high; clears all stages.
- in  input  1  serial data input.
- en  input  1  shift enable; 1 = shift on this edge, 0 = hold.
- dir  input  1  shift direction; 0 = toward MSB (LSB entry), 1 = toward LSB (MSB entry).
- out  output  1  serial data output (bit leaving the register).
- q  output  WIDTH  parallel view of all stages.
- pload  input  1  parallel load strobe (present only with the optional feature).
- pdata  input  WIDTH  parallel load data (present only with the optional feature).

Behaviour:
- One state register q[WIDTH-1:0]; all updates on rising clk only.
- Priority per edge: clr > pload (if compiled) > en shift > hold.
- clr=1 at an edge: q <= 0; out therefore 0 after that edge. Reset mid-stream discards all in-flight bits.
- en=1, dir=0: q <= {q[WIDTH-2:0], in}.
- en=1, dir=1: q <= {in, q[WIDTH-1:1]}.
- en=0: q holds; in ignored.
- out is combinational from q and dir: dir=0 -> q[WIDTH-1]; dir=1 -> q[0]. No extra register stage.
- Latency: a bit sampled on edge k (en=1, fixed dir) appears on out immediately after edge k+WIDTH-1, i.e. valid for the cycle following the WIDTH-th shift edge counting the sampling edge. For WIDTH=4: bit in at edge 1 is on out after edge 4.
- en gaps stretch latency by the number of hold cycles; no bits lost.
- Changing dir mid-stream is legal; bits reverse course, and out switches end immediately (combinational).
- X/undriven in before first reset: no requirement on q; after one clr edge q is fully defined.
- q and out are 0 from the first clr edge until the first 1 is shifted in.

Optional Feature:
- Macro SHIFT_REG_PLOAD_EN.
- Defined: pload/pdata ports exist; pload=1 at an edge (clr=0) loads q <= pdata regardless of en/dir; out reflects the new q after that edge.
- Not defined: ports absent; register supports only reset, shift and hold.

Test Plan:
- Reset: clr=1 for 1 edge with in=1, en=1 -> q=4'b0000, out=0 after edge; clr then 0.
- Left shift stream: dir=0, en=1, in pattern 0,0,1,1 repeated twice on consecutive edges after reset -> q after 4 edges = 4'b0011; out sequence from edge 4 onward = 0,0,1,1,0,0,1,1.
- Hold: load q=4'b0011 by shifting, then en=0 for 3 edges with in toggling -> q stays 4'b0011, out stays 0.
- Right shift: from q=4'b0000, dir=1, en=1, in=1,0,0,0 -> q=4'b0001 after 4 edges, out=q[0]=1.
- Reset mid-operation: q=4'b1011, assert clr with en=1, in=1 -> q=4'b0000 next edge; shifting resumes cleanly after release.
- With SHIFT_REG_PLOAD_EN: pload=1, pdata=4'b1010, en=1 -> q=4'b1010, out=1 (dir=0); clr=1 and pload=1 same edge -> q=4'b0000.
